// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: round count, key-schedule constants, mode encoding,
// and the state encoding of the round-key sequencer.
package sm4_pkg;

    localparam int          SM4_ROUNDS = 32;
    localparam logic [4:0]  LAST_IDX   = 5'd31;

    localparam logic        MODE_ENC   = 1'b0;
    localparam logic        MODE_DEC   = 1'b1;

    // System parameter FK, also used by key_expansion.
    localparam logic [31:0] FK0 = 32'ha3b1bac6;
    localparam logic [31:0] FK1 = 32'h56aa3350;
    localparam logic [31:0] FK2 = 32'h677d9197;
    localparam logic [31:0] FK3 = 32'hb27022dc;

    // Sequencer state encoding.
    localparam logic [2:0]  ST_IDLE      = 3'd0;
    localparam logic [2:0]  ST_KEXP_REQ  = 3'd1;
    localparam logic [2:0]  ST_KEXP_WAIT = 3'd2;
    localparam logic [2:0]  ST_PREFETCH  = 3'd3;
    localparam logic [2:0]  ST_ROUND     = 3'd4;
    localparam logic [2:0]  ST_DONE      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_KEXP_REQ  = ST_KEXP_REQ,
        S_KEXP_WAIT = ST_KEXP_WAIT,
        S_PREFETCH  = ST_PREFETCH,
        S_ROUND     = ST_ROUND,
        S_DONE      = ST_DONE
    } sched_state_e;

    // Round-key RAM index for logical step pos: forward for encrypt,
    // mirrored for decrypt. pos never exceeds 31, so no wrap.
    function automatic logic [4:0] rk_index(input logic mode, input logic [4:0] pos);
        return (mode == MODE_DEC) ? (LAST_IDX - pos) : pos;
    endfunction

endpackage

// File: rtl/sm4_rk_addr_gen.sv
// Round counter and round-key RAM address generator.
// The first advance after a clear loads the first index (prefetch); each
// further advance moves the address one step ahead of the round being
// executed, and saturates on the last index so it holds during round 31.
module sm4_rk_addr_gen
    import sm4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       advance,
    input  logic       mode,
    output logic [4:0] ikey_cnt,
    output logic [4:0] r,
    output logic       last
);

    logic       armed_q, armed_d;
    logic [4:0] pos_q, pos_d;
    logic [4:0] cnt_q, cnt_d;
    logic [4:0] r_q, r_d;
    logic       last_q, last_d;

    // Next address / round counter values.
    always_comb begin
        armed_d = armed_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        last_d  = last_q;
        if (clear) begin
            armed_d = 1'b0;
            pos_d   = 5'd0;
            cnt_d   = 5'd0;
            r_d     = 5'd0;
            last_d  = 1'b0;
        end else if (advance) begin
            if (!armed_q) begin
                armed_d = 1'b1;
                pos_d   = 5'd0;
                cnt_d   = rk_index(mode, 5'd0);
                r_d     = 5'd0;
                last_d  = 1'b0;
            end else begin
                // The round now starting is the one whose key is being read.
                r_d    = pos_q;
                last_d = (pos_q == LAST_IDX);
                if (pos_q != LAST_IDX) begin
                    pos_d = pos_q + 5'd1;
                    cnt_d = rk_index(mode, pos_q + 5'd1);
                end
            end
        end
    end

    // Address generator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            pos_q   <= 5'd0;
            cnt_q   <= 5'd0;
            r_q     <= 5'd0;
            last_q  <= 1'b0;
        end else begin
            armed_q <= armed_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            last_q  <= last_d;
        end
    end

    assign ikey_cnt = cnt_q;
    assign r        = r_q;
    assign last     = last_q;

endmodule

// File: rtl/sm4_round_sched.sv
// Sequencer for one SM4 block operation: optionally triggers key expansion,
// waits for it (with timeout), then streams the 32 round keys from the
// round-key RAM to the datapath in encrypt or decrypt order.
// start is a single-cycle request, honoured only while idle; there is no
// back-pressure and no queueing of requests made while busy.
module sm4_round_sched
    import sm4_pkg::*;
#(
    parameter int KEXP_TO = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         mode,
    input  logic         new_key,
    input  logic [127:0] mkey_in,
    output logic [127:0] mkey,
    output logic         key_exp_start,
    input  logic         key_exp_done,
    output logic [4:0]   ikey_cnt,
    input  logic [31:0]  ikey,
    output logic         dp_load,
    output logic         dp_round_en,
    output logic [31:0]  dp_rkey,
    output logic         dp_last,
    output logic         busy,
    output logic         done,
    output logic         key_ready,
    output logic         err,
    output logic [2:0]   state_dbg
);

    // KEXP_TO must be at least 33 so a normal expansion never times out.
    localparam int              TMO_W    = $clog2(KEXP_TO);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(KEXP_TO - 1);
    localparam logic [4:0]      R_LAST   = 5'(SM4_ROUNDS - 1);

    sched_state_e     state_q, state_d;
    logic             mode_q, mode_d;
    logic [127:0]     mkey_q, mkey_d;
    logic             key_ready_q, key_ready_d;
    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             dp_load_q, dp_load_d;
    logic             kstart_q, kstart_d;
    logic             round_en_q, round_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept;
    logic             ag_advance;
    logic             ag_clear;
    logic [4:0]       ag_r;
    logic             ag_last;

    // Next-state and captured-context logic.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        mkey_d      = mkey_q;
        key_ready_d = key_ready_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        accept      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    mode_d = mode;
                    mkey_d = mkey_in;
                    err_d  = 1'b0;
                    if (new_key || !key_ready_q) begin
                        state_d     = S_KEXP_REQ;
                        key_ready_d = 1'b0;
                    end else begin
                        state_d = S_PREFETCH;
                    end
                end
            end
            S_KEXP_REQ: begin
                state_d = S_KEXP_WAIT;
                tmo_d   = '0;
            end
            S_KEXP_WAIT: begin
                if (key_exp_done) begin
                    key_ready_d = 1'b1;
                    state_d     = S_PREFETCH;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_PREFETCH: begin
                state_d = S_ROUND;
            end
            S_ROUND: begin
                if (ag_r == R_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered control outputs, decoded from the state being entered.
    always_comb begin
        dp_load_d  = accept;
        kstart_d   = (state_d == S_KEXP_REQ);
        round_en_d = (state_d == S_ROUND);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        ag_advance = (state_d == S_PREFETCH) || (state_d == S_ROUND);
        ag_clear   = !ag_advance;
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE_ENC;
            mkey_q      <= '0;
            key_ready_q <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            dp_load_q   <= 1'b0;
            kstart_q    <= 1'b0;
            round_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            mkey_q      <= mkey_d;
            key_ready_q <= key_ready_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            dp_load_q   <= dp_load_d;
            kstart_q    <= kstart_d;
            round_en_q  <= round_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // mode_d is used so the prefetch address already reflects a new request.
    sm4_rk_addr_gen u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (ag_clear),
        .advance  (ag_advance),
        .mode     (mode_d),
        .ikey_cnt (ikey_cnt),
        .r        (ag_r),
        .last     (ag_last)
    );

    assign mkey          = mkey_q;
    assign key_exp_start = kstart_q;
    assign dp_load       = dp_load_q;
    assign dp_round_en   = round_en_q;
    assign dp_rkey       = ikey;
    assign dp_last       = ag_last;
    assign busy          = busy_q;
    assign done          = done_q;
    assign key_ready     = key_ready_q;
    assign err           = err_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_sm4_round_sched.sv
// Bench for sm4_round_sched: models the key expansion engine and the
// round-key RAM, and predicts each operation's timing and key order.
module tb_sm4_round_sched;

    localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [31:0]  STD_RK0  = 32'hf12186f9;
    localparam logic [31:0]  STD_RK31 = 32'h9124a012;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         mode;
    logic         new_key;
    logic [127:0] mkey_in;
    logic [127:0] mkey;
    logic         key_exp_start;
    logic         key_exp_done;
    logic [4:0]   ikey_cnt;
    logic [31:0]  ikey;
    logic         dp_load;
    logic         dp_round_en;
    logic [31:0]  dp_rkey;
    logic         dp_last;
    logic         busy;
    logic         done;
    logic         key_ready;
    logic         err;
    logic [2:0]   state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    bit key_ready_m = 1'b0;

    sm4_round_sched #(.KEXP_TO(40)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .new_key       (new_key),
        .mkey_in       (mkey_in),
        .mkey          (mkey),
        .key_exp_start (key_exp_start),
        .key_exp_done  (key_exp_done),
        .ikey_cnt      (ikey_cnt),
        .ikey          (ikey),
        .dp_load       (dp_load),
        .dp_round_en   (dp_round_en),
        .dp_rkey       (dp_rkey),
        .dp_last       (dp_last),
        .busy          (busy),
        .done          (done),
        .key_ready     (key_ready),
        .err           (err),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- key expansion engine + round-key RAM model ----------------
    // Engine: 32 write cycles starting the cycle after key_exp_start,
    // done high during the last one. Contents are random per key, except the
    // reference key which carries its known first and last round keys.
    logic [31:0] rk_mem [32];
    int eng_cnt = 0;
    bit eng_en  = 1'b1;

    initial begin
        ikey = 32'h0;
        for (int i = 0; i < 32; i++) rk_mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        ikey <= rk_mem[ikey_cnt];
        if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
        if (key_exp_start && eng_en) begin
            eng_cnt <= 32;
            for (int i = 0; i < 32; i++) rk_mem[i] <= $urandom;
            if (mkey == STD_KEY) begin
                rk_mem[0]  <= STD_RK0;
                rk_mem[31] <= STD_RK31;
            end
        end
    end

    assign key_exp_done = (eng_cnt == 1);

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Key index the datapath must receive on round r.
    function automatic logic [4:0] ref_idx(input logic m, input int r);
        return m ? 5'(31 - r) : 5'(r);
    endfunction

    // ---------------- driver + reference model ----------------
    // One operation: start is driven for one cycle (cycle 0), outputs are
    // sampled mid-cycle from cycle 1 on. poke_cyc re-pulses start while busy;
    // rst_round asserts reset during that round.
    task automatic run_op(input logic m, input logic nk, input logic [127:0] key,
                          input bit eng_on, input int poke_cyc, input int rst_round);
        bit kexp;
        int cyc, rnd, n_load, n_kst, n_stray_last, done_cyc, err_cyc, first_rnd;
        logic [4:0] exp_cnt;
        kexp = nk || !key_ready_m;
        eng_en = eng_on;
        @(negedge clk);
        start = 1'b1; mode = m; new_key = nk; mkey_in = key;
        @(negedge clk);
        start = 1'b0; mode = 1'($urandom); new_key = 1'($urandom);
        mkey_in = {$urandom, $urandom, $urandom, $urandom};
        cyc = 1; rnd = 0; n_load = 0; n_kst = 0; n_stray_last = 0;
        done_cyc = -1; err_cyc = -1; first_rnd = -1;
        check_eq("c1_err", err, 1'b0);
        check_eq("c1_mkey", mkey, key);
        check_eq("c1_busy", busy, 1'b1);
        check_eq("c1_kstart", key_exp_start, kexp);
        if (kexp) check_eq("c1_kready", key_ready, 1'b0);
        while (cyc <= 120 && done_cyc < 0 && err_cyc < 0) begin
            start = (cyc == poke_cyc);
            n_load += int'(dp_load);
            n_kst  += int'(key_exp_start);
            if (kexp && cyc >= 2 && cyc <= 33) check_eq("wait_cnt", ikey_cnt, 5'd0);
            if (eng_on && cyc == (kexp ? 34 : 1)) check_eq("pf_cnt", ikey_cnt, ref_idx(m, 0));
            if (dp_round_en) begin
                if (first_rnd < 0) first_rnd = cyc;
                check_eq("rkey", dp_rkey, rk_mem[ref_idx(m, rnd)]);
                exp_cnt = (rnd < 31) ? ref_idx(m, rnd + 1) : ref_idx(m, 31);
                check_eq("ikey_cnt", ikey_cnt, exp_cnt);
                check_eq("dp_last", dp_last, (rnd == 31));
                if (key == STD_KEY && rnd == 0)  check_eq("kat_r0",  dp_rkey, m ? STD_RK31 : STD_RK0);
                if (key == STD_KEY && rnd == 31) check_eq("kat_r31", dp_rkey, m ? STD_RK0 : STD_RK31);
                if (rnd == rst_round) begin
                    rst_n = 1'b0;
                    #1;
                    check_eq("rst_ctrl", {key_exp_start, dp_load, dp_round_en, dp_last,
                                          busy, done, key_ready, err}, 8'h00);
                    check_eq("rst_mkey", mkey, 128'h0);
                    check_eq("rst_cnt", ikey_cnt, 5'd0);
                    start = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                    #1;
                    check_eq("rst_kready", key_ready, 1'b0);
                    key_ready_m = 1'b0;
                    return;
                end
                rnd++;
            end else begin
                n_stray_last += int'(dp_last);
            end
            if (done) done_cyc = cyc;
            if (err)  err_cyc = cyc;
            if (done_cyc < 0 && err_cyc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check_eq("n_load", n_load, 1);
        check_eq("n_kstart", n_kst, int'(kexp));
        check_eq("stray_last", n_stray_last, 0);
        if (eng_on) begin
            check_eq("done_cyc", done_cyc, kexp ? 67 : 34);
            check_eq("first_rnd", first_rnd, kexp ? 35 : 2);
            check_eq("n_rounds", rnd, 32);
            check_eq("done_busy", busy, 1'b1);
            check_eq("done_kready", key_ready, 1'b1);
            key_ready_m = 1'b1;
        end else begin
            check_eq("tmo_cyc", err_cyc, 42);
            check_eq("tmo_done", done_cyc, -1);
            check_eq("tmo_busy", busy, 1'b0);
            check_eq("tmo_kready", key_ready, 1'b0);
            check_eq("tmo_rounds", rnd, 0);
            key_ready_m = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] k;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; new_key = 1'b0; mkey_in = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_ctrl", {key_exp_start, dp_load, dp_round_en, dp_last,
                                busy, done, key_ready, err}, 8'h00);
        check_eq("reset_mkey", mkey, 128'h0);
        check_eq("reset_cnt", ikey_cnt, 5'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op(1'b0, 1'b1, STD_KEY, 1'b1, -1, -1);   // encrypt with expansion
        run_op(1'b1, 1'b0, STD_KEY, 1'b1, 10, -1);   // cached decrypt, start poked in ROUND
        run_op(1'b0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, -1); // back-to-back
        repeat (2) @(negedge clk);
        run_op(1'b0, 1'b0, STD_KEY, 1'b1, -1, 10);   // reset during round 10
        run_op(1'b1, 1'b0, STD_KEY, 1'b1, 50, -1);   // key lost by reset: expands again
        run_op(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, -1); // timeout
        run_op(1'b0, 1'b0, STD_KEY, 1'b1, -1, -1);   // err cleared, expansion reruns

        for (int i = 0; i < 8; i++) begin
            k = ($urandom_range(0, 2) == 0) ? STD_KEY : {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(1'($urandom), 1'($urandom), k, 1'b1,
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 60)) : -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sm4_round_sched.md
Name: sm4_round_sched

Overview:
Sequencer for one SM4 block operation. It decides whether the round keys must be re-expanded, and if so pulses the key expansion engine and waits for it to finish. It then reads the 32 round keys out of the expansion engine's round-key RAM, in encrypt or decrypt order, and streams them to the SM4 round datapath one per cycle. It sits between the envelope top-level control and the key_expansion / SM4 datapath pair.

Parameters:
KEXP_TO, 40, maximum cycles waited in KEXP_WAIT for key_exp_done before declaring an error (must be >= 33).

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  request one block operation; accepted only in IDLE
mode  in  1  0 = encrypt (keys 0..31), 1 = decrypt (keys 31..0)
new_key  in  1  1 = re-expand keys from mkey_in before the rounds
mkey_in  in  128  master key, sampled on the accepted start
mkey  out  128  registered master key to key_expansion
key_exp_start  out  1  one-cycle pulse to key_expansion, aligned with mkey
key_exp_done  in  1  from key_expansion; high during its last write cycle
ikey_cnt  out  5  round-key RAM read address
ikey  in  32  round-key RAM read data; 1-cycle registered latency
dp_load  out  1  one-cycle pulse: datapath loads its input block
dp_round_en  out  1  datapath executes one round this cycle
dp_rkey  out  32  round key for this cycle (equals ikey)
dp_last  out  1  high with dp_round_en on round 31
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion
key_ready  out  1  a valid expanded key is held in the RAM
err  out  1  sticky key-expansion timeout flag; cleared by the next accepted start

Behaviour:
- Clocking and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values:
  - state = IDLE.
  - All outputs 0, including mkey, ikey_cnt, key_ready and err.
  - The reset takes effect immediately, including mid-operation; no partial completion.
- States: IDLE, KEXP_REQ, KEXP_WAIT, PREFETCH, ROUND, DONE.
- IDLE:
  - start=1 is accepted: capture mode and mkey_in, clear err.
  - Go to KEXP_REQ if new_key=1 or key_ready=0; otherwise go to PREFETCH.
  - start while not in IDLE is ignored (no queueing).
- dp_load pulses in the first cycle after acceptance, whichever state that is.
- KEXP_REQ (1 cycle):
  - key_exp_start=1 with mkey valid; key_ready cleared.
  - Then go to KEXP_WAIT and clear the timeout counter.
- KEXP_WAIT:
  - ikey_cnt is held at 0; no RAM reads depend on it, because the engine owns the address while WORKING.
  - On key_exp_done: set key_ready and go to PREFETCH.
  - If the counter reaches KEXP_TO first: set err, key_ready stays 0, go to IDLE, no done pulse.
- PREFETCH (1 cycle): ikey_cnt = first index (0 for encrypt, 31 for decrypt).
- ROUND (exactly 32 cycles, round counter r = 0..31):
  - dp_round_en=1, dp_rkey=ikey.
  - Key index delivered on round r: r for encrypt, 31-r for decrypt.
  - ikey_cnt is driven one step ahead, i.e. the index for round r+1.
  - On r=31, ikey_cnt holds its value; dp_last=1.
  - Then go to DONE.
- DONE (1 cycle): done=1, busy=1; then go to IDLE.
- Latency, with the accepted start in cycle 0:
  - Cached key: done in cycle 34; rounds in cycles 2..33.
  - Re-expansion: done in cycle 67; key_exp_start in cycle 1; rounds in cycles 35..66.
- Index arithmetic is 5-bit. Decrypt computes 31-r; no wrap occurs because r never exceeds 31.
- dp_rkey is combinationally equal to ikey. dp_round_en, dp_last and all control outputs are registered.

Decomposition:
- Package sm4_pkg:
  - State encoding localparams.
  - SM4_ROUNDS = 32.
  - FK0..FK3 constants (shared with key_expansion).
  - MODE_ENC/MODE_DEC.
- One natural sub-module: sm4_rk_addr_gen.
  - Round counter plus encrypt/decrypt address mapping.
  - Inputs: clear, advance, mode. Outputs: ikey_cnt, r, last.

Test Plan:
- Reset mid-ROUND: assert rst_n=0 at r=10 -> all outputs 0 immediately; after release, key_ready=0 and the next start with new_key=0 still runs expansion.
- Encrypt, new_key=1, key 0123456789abcdeffedcba9876543210:
  - key_exp_start in cycle 1; done in cycle 67.
  - dp_rkey on r=0 is f12186f9; on r=31 is 9124a012.
- Decrypt, same key, new_key=0 with key_ready=1:
  - No key_exp_start; done in cycle 34.
  - dp_rkey on r=0 is 9124a012; on r=31 is f12186f9.
  - ikey_cnt sequence is 31,30,...,0.
- Start pulsed while busy in ROUND: ignored; exactly one done; no extra dp_load.
- Timeout: key_exp_done tied low, KEXP_TO=40 -> err=1 forty cycles after entering KEXP_WAIT; back in IDLE; no done; err clears on the next start.
- Back-to-back: start asserted in the cycle right after done -> accepted; dp_load in the next cycle; 32 rounds repeat correctly.
